// File: rtl/core_loader_pkg.sv
// Shared types and constants for the core boot/supervision controller.
// Holds the loader state encoding and the riscv-tests exit convention.
package core_loader_pkg;

  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    RUN,
    PASS_S,
    FAIL_S,
    TIMEOUT_S,
    OVF_S
  } state_e;

  localparam int ECALL_EXIT = 93;
  localparam int PASS_GP    = 1;

  function automatic logic is_terminal(input state_e s);
    return (s == PASS_S) || (s == FAIL_S) ||
           (s == TIMEOUT_S) || (s == OVF_S);
  endfunction

endpackage

// File: rtl/core_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// A short final word is zero-filled above the last byte.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        word_last_o
);

  logic [1:0]  idx_q;
  logic [23:0] acc_q;

  // acc_q is zero above idx_q, so OR-ing in the byte also zero-fills
  always_comb begin
    word_o       = {8'h00, acc_q} |
                   ({24'h000000, byte_i} << {idx_q, 3'b000});
    word_valid_o = strobe_i && ((idx_q == 2'd3) || last_i);
    word_last_o  = strobe_i && last_i;
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (word_valid_o) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (strobe_i) begin
      idx_q <= idx_q + 2'd1;
      acc_q <= word_o[23:0];
    end
  end

endmodule

// File: rtl/core_loader.sv
// Boot loader and run supervisor for the RV32 core: image load,
// core release, exit detection on gp/a7, cycle count and timeout.
module core_loader #(
  parameter int WIDTH          = 32,
  parameter int IMEM_DEPTH     = 512,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             core_reset,
  output logic             ins_mem_en,
  output logic [WIDTH-1:0] ins_mem_addr,
  output logic [WIDTH-1:0] ins_mem_data,
  input  logic [WIDTH-1:0] gp,
  input  logic [WIDTH-1:0] a7,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             overflow,
  output logic [WIDTH-1:0] fail_test,
  output logic [WIDTH-1:0] cycle_count
);

  import core_loader_pkg::*;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(IMEM_DEPTH);
  localparam logic [WIDTH-1:0] TMO_W   = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] EXIT_W  = WIDTH'(ECALL_EXIT);
  localparam logic [WIDTH-1:0] PASS_W  = WIDTH'(PASS_GP);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] wcnt_q, wcnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ftest_q, ftest_d;
  logic [WIDTH-1:0] addr_q, data_q;
  logic             arm_q, arm_d;
  logic             wr_d, clr_d;
  logic             en_q, core_rst_q;
  logic             pass_q, fail_q, tmo_q, ovf_q, done_q;

  logic             accept;
  logic [31:0]      pk_word;
  logic             pk_valid, pk_last;

  assign s_ready = (state_q == LOAD) && !reset;
  assign accept  = s_valid && s_ready;

  byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (clr_d),
    .byte_i       (s_data),
    .strobe_i     (accept),
    .last_i       (s_last),
    .word_o       (pk_word),
    .word_valid_o (pk_valid),
    .word_last_o  (pk_last)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    ftest_d = ftest_q;
    wr_d    = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (pk_valid) begin
          if (wcnt_q == DEPTH_W) begin
            state_d = OVF_S;
          end else begin
            wr_d   = 1'b1;
            wcnt_d = wcnt_q + ONE_W;
            if (pk_last) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = RUN;
        cnt_d   = '0;
        arm_d   = 1'b0;
      end
      RUN: begin
        // stale a7==93 left in unreset registers must not end the run
        if (arm_q && (a7 == EXIT_W)) begin
          if (gp == PASS_W) begin
            state_d = PASS_S;
          end else begin
            state_d = FAIL_S;
            ftest_d = gp >> 1;
          end
        end else if (cnt_q == TMO_W) begin
          state_d = TIMEOUT_S;
        end
        if (state_d == RUN) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + ONE_W;
        end
        if (a7 != EXIT_W) arm_d = 1'b1;
      end
      PASS_S, FAIL_S, TIMEOUT_S, OVF_S: begin
        if (restart) begin
          state_d = LOAD;
          clr_d   = 1'b1;
          wcnt_d  = '0;
          cnt_d   = '0;
          arm_d   = 1'b0;
          ftest_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
        clr_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LOAD;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      ftest_q    <= '0;
      arm_q      <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cnt_q      <= cnt_d;
      ftest_q    <= ftest_d;
      arm_q      <= arm_d;
      en_q       <= wr_d;
      if (wr_d) begin
        addr_q <= wcnt_q;
        data_q <= WIDTH'(pk_word);
      end
      core_rst_q <= (state_d != RUN);
      pass_q     <= (state_d == PASS_S);
      fail_q     <= (state_d == FAIL_S);
      tmo_q      <= (state_d == TIMEOUT_S);
      ovf_q      <= (state_d == OVF_S);
      done_q     <= is_terminal(state_d);
    end
  end

  assign core_reset   = core_rst_q;
  assign ins_mem_en   = en_q;
  assign ins_mem_addr = addr_q;
  assign ins_mem_data = data_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = tmo_q;
  assign overflow     = ovf_q;
  assign fail_test    = ftest_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_core_loader.sv
// Randomized bench for core_loader with a behavioural image/run model.
// Small IMEM_DEPTH and TIMEOUT_CYCLES keep overflow and timeout reachable.
module tb_core_loader;

  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic        clock;
  logic        reset;
  logic        restart;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        core_reset;
  logic        ins_mem_en;
  logic [31:0] ins_mem_addr;
  logic [31:0] ins_mem_data;
  logic [31:0] gp;
  logic [31:0] a7;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic        overflow;
  logic [31:0] fail_test;
  logic [31:0] cycle_count;

  core_loader #(
    .WIDTH          (32),
    .IMEM_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .restart      (restart),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .core_reset   (core_reset),
    .ins_mem_en   (ins_mem_en),
    .ins_mem_addr (ins_mem_addr),
    .ins_mem_data (ins_mem_data),
    .gp           (gp),
    .a7           (a7),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .overflow     (overflow),
    .fail_test    (fail_test),
    .cycle_count  (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  logic [7:0]  img [64];
  int          img_len;
  logic [31:0] a7s [40];
  logic [31:0] gps [40];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // write scoreboard: every strobe must match the next expected word
  always @(negedge clock) begin
    if (ins_mem_en === 1'b1) begin
      wlog_a.push_back(ins_mem_addr);
      wlog_d.push_back(ins_mem_data);
      chk("wr_core_held", 32'(core_reset), 32'd1);
      if (exp_a.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                 ins_mem_addr, ins_mem_data);
      end else begin
        chk("wr_addr", ins_mem_addr, exp_a.pop_front());
        chk("wr_data", ins_mem_data, exp_d.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int n_words();
    return (img_len + 3) / 4;
  endfunction

  task automatic load_expect();
    int nw;
    nw = n_words();
    if (nw > DEPTH) nw = DEPTH;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      d = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < img_len) d = d | (32'(img[4 * w + b]) << (8 * b));
      exp_a.push_back(32'(w));
      exp_d.push_back(d);
    end
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 40; i++) begin
      a7s[i] = 32'd0;
      gps[i] = 32'd0;
    end
  endtask

  function automatic logic [31:0] non_exit();
    logic [31:0] v;
    v = 32'($urandom_range(0, 200));
    if (v == 32'd93) v = 32'd94;
    return v;
  endfunction

  // exit needs a non-93 a7 on some earlier RUN cycle; exit beats timeout
  task automatic predict(output int j, output int kind);
    bit armed;
    bit found;
    armed = 1'b0;
    found = 1'b0;
    j = TO;
    kind = 2;
    for (int i = 0; i <= TO; i++) begin
      if (!found) begin
        if (armed && a7s[i] == 32'd93) begin
          found = 1'b1;
          j = i;
          kind = (gps[i] == 32'd1) ? 0 : 1;
        end else if (i == TO) begin
          found = 1'b1;
          j = i;
          kind = 2;
        end
        if (a7s[i] != 32'd93) armed = 1'b1;
      end
    end
  endtask

  task automatic send(input int n_send, input int maxgap);
    for (int k = 0; k < n_send; k++) begin
      int  gap;
      int  budget;
      bit  rdy;
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        step();
      end
      s_valid = 1'b1;
      s_data  = img[k];
      s_last  = (k == img_len - 1);
      budget  = 0;
      rdy     = 1'b0;
      while (!rdy && budget < 20) begin
        rdy = s_ready;
        step();
        budget++;
      end
      if (!rdy) chk("byte_accept", 32'(rdy), 32'd1);
      if (((k % 4) == 3 || k == img_len - 1) && (k / 4) < DEPTH)
        chk("wr_latency", 32'(ins_mem_en), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_en"}, 32'(ins_mem_en), 32'd0);
    chk({tag, "_addr"}, ins_mem_addr, 32'd0);
    chk({tag, "_data"}, ins_mem_data, 32'd0);
    chk({tag, "_flags"},
        32'({done, pass, fail, timeout, overflow}), 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
    chk({tag, "_fail_test"}, fail_test, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_ready_in_rst"}, 32'(s_ready), 32'd0);
    step();
    check_reset_vals(tag);
    chk({tag, "_ready_rst_cyc"}, 32'(s_ready), 32'd0);
    reset = 1'b0;
    exp_a.delete();
    exp_d.delete();
    #1;
    chk({tag, "_ready_after"}, 32'(s_ready), 32'd1);
  endtask

  task automatic load_and_release(input string tag, input int maxgap);
    wlog_a.delete();
    wlog_d.delete();
    load_expect();
    send(img_len, maxgap);
    chk({tag, "_drain_held"}, 32'(core_reset), 32'd1);
    step();
    chk({tag, "_release"}, 32'(core_reset), 32'd0);
    chk({tag, "_all_written"}, 32'(exp_a.size()), 32'd0);
  endtask

  task automatic run_and_check(input string tag);
    int j;
    int kind;
    predict(j, kind);
    for (int i = 0; i <= j; i++) begin
      a7 = a7s[i];
      gp = gps[i];
      step();
      if (i < j) chk({tag, "_running"}, 32'({done, core_reset}), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(kind == 0));
    chk({tag, "_fail"}, 32'(fail), 32'(kind == 1));
    chk({tag, "_timeout"}, 32'(timeout), 32'(kind == 2));
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_core_rst"}, 32'(core_reset), 32'd1);
    chk({tag, "_cycles"}, cycle_count, 32'(j));
    chk({tag, "_fail_test"}, fail_test,
        (kind == 1) ? (gps[j] >> 1) : 32'd0);
    for (int h = 0; h < 2; h++) begin
      a7      = $urandom;
      gp      = $urandom;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    chk({tag, "_hold_cycles"}, cycle_count, 32'(j));
    chk({tag, "_hold_done"}, 32'(done), 32'd1);
    chk({tag, "_hold_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk({tag, "_flags"},
        32'({done, pass, fail, timeout, overflow}), 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
    chk({tag, "_fail_test"}, fail_test, 32'd0);
    chk({tag, "_core_rst"}, 32'(core_reset), 32'd1);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic overflow_case(input string tag, input int maxgap);
    int last_idx;
    wlog_a.delete();
    wlog_d.delete();
    load_expect();
    last_idx = 4 * DEPTH + 3;
    if (last_idx > img_len - 1) last_idx = img_len - 1;
    send(last_idx + 1, maxgap);
    chk({tag, "_overflow"}, 32'(overflow), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_rst"}, 32'(core_reset), 32'd1);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    for (int h = 0; h < 3; h++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    chk({tag, "_nwrites"}, 32'(wlog_a.size()), 32'(DEPTH));
    chk({tag, "_queue"}, 32'(exp_a.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] imgA [8];
    logic [7:0] imgB [5];
    reset   = 1'b1;
    restart = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    gp      = 32'd0;
    a7      = 32'd0;
    do_reset("por");

    // A: two full words, stale exit value then a real pass
    imgA = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img_len = 8;
    for (int i = 0; i < 8; i++) img[i] = imgA[i];
    load_and_release("A", 0);
    chk("A_nwrites", 32'(wlog_a.size()), 32'd2);
    if (wlog_a.size() >= 2) begin
      chk("A_w0_addr", wlog_a[0], 32'd0);
      chk("A_w0_data", wlog_d[0], 32'h00000013);
      chk("A_w1_addr", wlog_a[1], 32'd1);
      chk("A_w1_data", wlog_d[1], 32'h00100093);
    end
    clear_seq();
    a7s[0] = 32'd93; gps[0] = 32'd1;
    a7s[1] = 32'd0;  gps[1] = 32'd1;
    a7s[2] = 32'd93; gps[2] = 32'd1;
    run_and_check("A");
    chk("A_lit_pass", 32'(pass), 32'd1);
    chk("A_lit_cycles", cycle_count, 32'd2);
    do_restart("A_rs");

    // B: short final word zero-filled, then a failing exit
    imgB = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    img_len = 5;
    for (int i = 0; i < 5; i++) img[i] = imgB[i];
    load_and_release("B", 1);
    chk("B_nwrites", 32'(wlog_a.size()), 32'd2);
    if (wlog_a.size() >= 2) begin
      chk("B_w0_data", wlog_d[0], 32'hDDCCBBAA);
      chk("B_w1_data", wlog_d[1], 32'h000000EE);
    end
    clear_seq();
    a7s[0] = 32'd0;  gps[0] = 32'h0B;
    a7s[1] = 32'd93; gps[1] = 32'h0B;
    run_and_check("B");
    chk("B_lit_fail_test", fail_test, 32'd5);
    chk("B_lit_fail", 32'(fail), 32'd1);
    do_restart("B_rs");

    // C: a7 never signals exit
    img_len = 4;
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    load_and_release("C", 1);
    clear_seq();
    run_and_check("C");
    chk("C_lit_timeout", 32'(timeout), 32'd1);
    chk("C_lit_cycles", cycle_count, 32'd20);
    do_restart("C_rs");
    chk("C_lit_rs_cycles", cycle_count, 32'd0);

    // D: image larger than instruction memory
    img_len = 4 * DEPTH + 8;
    for (int i = 0; i < img_len; i++) img[i] = 8'($urandom);
    overflow_case("D", 1);
    do_restart("D_rs");

    // E: reset after half a word discards the partial bytes
    img_len = 8;
    img[0] = 8'h11;
    img[1] = 8'h22;
    send(2, 0);
    do_reset("E_rst");
    img_len = 4;
    img[0] = 8'h44; img[1] = 8'h55; img[2] = 8'h66; img[3] = 8'h77;
    load_and_release("E", 0);
    if (wlog_a.size() >= 1) chk("E_lit_w0", wlog_d[0], 32'h77665544);
    clear_seq();
    a7s[0] = 32'd5;  gps[0] = 32'd1;
    a7s[1] = 32'd93; gps[1] = 32'd1;
    run_and_check("E");
    do_restart("E_rs");

    // randomized images and run traces
    for (int it = 0; it < 16; it++) begin
      img_len = $urandom_range(1, 4 * DEPTH + 6);
      for (int i = 0; i < img_len; i++) img[i] = 8'($urandom);
      if (n_words() > DEPTH) begin
        overflow_case("R_ovf", 2);
        do_restart("R_ovf_rs");
      end else if ((it % 5) == 4) begin
        load_and_release("R_abort", 2);
        for (int c = 0; c < 3; c++) begin
          a7 = 32'd0;
          step();
        end
        do_reset("R_abort_rst");
      end else begin
        load_and_release("R", 2);
        clear_seq();
        if (($urandom % 4) == 0) begin
          for (int i = 0; i < 40; i++) a7s[i] = non_exit();
        end else begin
          for (int i = 0; i < 40; i++) begin
            a7s[i] = (($urandom % 3) == 0) ? 32'd93 : non_exit();
            gps[i] = (($urandom % 2) == 0) ? 32'd1 : $urandom;
          end
          if (($urandom % 2) == 0) a7s[0] = 32'd93;
        end
        run_and_check("R");
        do_restart("R_rs");
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
